// File: rtl/pulse_peak_finder.sv
// Pulse detector with hysteresis and holdoff: captures peak amplitude, peak time
// and width per pulse, queues records in a small FIFO behind a valid/ready port.
module pulse_peak_finder #(
  parameter int DATA_WIDTH = 16,
  parameter int TIME_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] input_data,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  input  logic        [DATA_WIDTH-2:0] hysteresis,
  output logic signed [DATA_WIDTH-1:0] peak_amplitude,
  output logic        [TIME_WIDTH-1:0] peak_time,
  output logic        [TIME_WIDTH-1:0] pulse_width,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic                         busy,
  output logic        [7:0]            dropped_count
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

  function automatic logic [TIME_WIDTH-1:0] sat_inc_time(input logic [TIME_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc_8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  function automatic logic signed [DATA_WIDTH:0] sext1(input logic signed [DATA_WIDTH-1:0] v);
    return {v[DATA_WIDTH-1], v};
  endfunction

  // Stage 0: sample register and its index
  logic signed [DATA_WIDTH-1:0] s_p0;
  logic        [TIME_WIDTH-1:0] t_p0;
  logic                         vld_p0;

  always_ff @(posedge clk) begin
    s_p0 <= input_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      t_p0   <= '0;
    end else begin
      vld_p0 <= 1'b1;
      t_p0   <= vld_p0 ? t_p0 + 1'b1 : '0;
    end
  end

  // Stage 1: pulse tracking FSM
  state_t                       state, state_nxt;
  logic signed [DATA_WIDTH:0]   exit_lvl, exit_p1;
  logic signed [DATA_WIDTH-1:0] peak_p1;
  logic        [TIME_WIDTH-1:0] ptime_p1, width_p1;
  logic        [HC_W-1:0]       hcnt;
  logic                         arm, push_req;

  assign exit_lvl = sext1(threshold) - $signed({2'b00, hysteresis});

  always_comb begin
    state_nxt = state;
    arm       = 1'b0;
    push_req  = 1'b0;
    case (state)
      IDLE: begin
        if (vld_p0 && (s_p0 > threshold)) begin
          arm       = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (vld_p0 && (sext1(s_p0) < exit_p1)) begin
          push_req  = 1'b1;
          state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
        end
      end
      HOLD: begin
        if (hcnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      if (push_req)          hcnt <= HC_W'(HOLDOFF - 1);
      else if (state == HOLD) hcnt <= hcnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arm) begin
      exit_p1  <= exit_lvl;
      peak_p1  <= s_p0;
      ptime_p1 <= t_p0;
      width_p1 <= {{(TIME_WIDTH-1){1'b0}}, 1'b1};
    end else if (state == ARMED && !push_req) begin
      width_p1 <= sat_inc_time(width_p1);
      // strict compare keeps the first of equal maxima
      if (s_p0 > peak_p1) begin
        peak_p1  <= s_p0;
        ptime_p1 <= t_p0;
      end
    end
  end

  assign busy = (state != IDLE);

  // Stage 2: result FIFO
  logic signed [DATA_WIDTH-1:0] amp_mem [FIFO_DEPTH];
  logic        [TIME_WIDTH-1:0] time_mem[FIFO_DEPTH];
  logic        [TIME_WIDTH-1:0] wid_mem [FIFO_DEPTH];
  logic        [AW-1:0]         wr_ptr, rd_ptr;
  logic        [AW:0]           count;
  logic                         full, push, pop;

  assign full         = (count == (AW+1)'(FIFO_DEPTH));
  assign result_valid = (count != '0);
  assign pop          = result_valid && result_ready;
  assign push         = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      amp_mem[wr_ptr]  <= peak_p1;
      time_mem[wr_ptr] <= ptime_p1;
      wid_mem[wr_ptr]  <= width_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      dropped_count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) dropped_count <= sat_inc_8(dropped_count);
    end
  end

  assign peak_amplitude = result_valid ? amp_mem[rd_ptr]  : '0;
  assign peak_time      = result_valid ? time_mem[rd_ptr] : '0;
  assign pulse_width    = result_valid ? wid_mem[rd_ptr]  : '0;

endmodule

// File: doc/pulse_peak_finder.md
Name: pulse_peak_finder

Overview:
- Consumer end of the signal chain: takes one filter output stream (`output_data_vN`, driven by the `exp_sig_gen` test source) and turns each detected pulse into one result record.
- A record holds peak amplitude, peak timestamp and pulse width.
- Records are queued in a small FIFO and read out through a valid/ready handshake, so the bench or a readout block can check each filter version's response pulse by pulse.

Parameters:
- DATA_WIDTH, 16, width of the signed input sample; equals SIZE_FILTER_DATA.
- TIME_WIDTH, 16, width of the timestamp counter and of the pulse width field.
- FIFO_DEPTH, 4, number of result records held; power of two, at least 2.
- HOLDOFF, 8, dead-time cycles after a pulse ends during which no new pulse is armed; 0 is legal.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- input_data  in  DATA_WIDTH  signed filter output sample, one per clk.
- threshold  in  DATA_WIDTH  signed arming level.
- hysteresis  in  DATA_WIDTH-1  unsigned; the pulse ends below threshold-hysteresis.
- peak_amplitude  out  DATA_WIDTH  signed peak of the FIFO head record.
- peak_time  out  TIME_WIDTH  sample index of the peak, head record.
- pulse_width  out  TIME_WIDTH  samples at or above the exit level, head record.
- result_valid  out  1  FIFO not empty.
- result_ready  in  1  consumer accepts the head record.
- busy  out  1  state is not IDLE.
- dropped_count  out  8  results lost because the FIFO was full; saturates at 255.

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - All outputs 0, result_valid 0, busy 0.
  - FIFO empty, state IDLE, timestamp 0.
  - Any pulse in progress is discarded; no partial record is ever pushed.
- Sample register:
  - input_data is registered once into s.
  - Sample index = number of clk edges since reset deasserted, minus 1. The first sample captured after reset has index 0.
  - The free-running TIME_WIDTH counter tracks that index and wraps modulo 2^TIME_WIDTH.
- Exit level: exit_lvl = threshold - hysteresis, computed at DATA_WIDTH+1 bits signed, so there is no wrap.
- IDLE state:
  - If s > threshold (signed, strict): latch threshold and exit_lvl, set peak=s, peak_time=index(s), width=1, go to ARMED.
- ARMED state:
  - Latched threshold and exit_lvl are used; port changes are ignored until the next arming.
  - If s < exit_lvl: push {peak, peak_time, width} and go to HOLDOFF. If HOLDOFF=0, go straight to IDLE instead; that s is not re-evaluated for arming.
  - Else: width increments (saturates at all-ones). If s > peak (strict), update peak and peak_time. On equal maxima the first occurrence is kept.
  - The exit sample is not counted in width.
- HOLDOFF state:
  - A counter loads HOLDOFF-1 on entry and decrements each cycle.
  - When it reaches 0, go to IDLE. Samples seen during HOLDOFF never arm.
- FIFO:
  - A push and a pop happen at the clk edge.
  - A pushed record appears at the head (result_valid=1) one cycle after the push edge if the FIFO was empty.
  - Pop occurs when result_valid & result_ready; the next record, or valid=0, appears the following cycle.
  - Push when full with a simultaneous pop: accepted. Push when full without a pop: record dropped, dropped_count increments (saturating).
  - result_ready while empty has no effect.
  - Head outputs hold their value while valid & !ready; they read 0 while empty.
- Timestamp wrap: peak_time is reported modulo 2^TIME_WIDTH. The width field is independent of the wrap.
- busy = (state != IDLE).

Test Plan:
- Single pulse, threshold=100, hysteresis=10, samples idx0..9 = 0,0,50,150,300,250,120,95,80,0
  -> one record: amplitude 300, time 4, width 5.
  -> result_valid rises 2 cycles after the idx8 sample is presented.
- Hysteresis: threshold=100, hysteresis=10, samples 0,150,95,105,95,150,0
  -> exactly one record: amplitude 150, time 1, width 5.
- Equal peaks: threshold=100, samples 0,200,300,300,50
  -> amplitude 300, time 2, width 3.
- Backpressure: result_ready=0, FIFO_DEPTH=4, six separated pulses with amplitudes 110..160
  -> 4 records stored, dropped_count=2.
  -> on raising result_ready, reads 110,120,130,140 in order, then result_valid=0.
- Holdoff: HOLDOFF=8; a second crossing 3 samples after the first pulse exits is ignored, a crossing 10 samples after is recorded
  -> 2 records total.
- Reset mid-pulse: assert reset while ARMED, then deassert
  -> no record, busy=0, dropped_count=0, the next pulse's time is measured from the new index 0.
